// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Constants and types shared by the memory-bus arbiter and its ID FIFO.
//   BUS_ID_*  : requester tag stored per outstanding transaction
//   BUS_STRB_W: byte-enable width of every bus
//   arb_state_e: grant-lock state of the arbiter
package mem_bus_arbiter_pkg;

  localparam logic BUS_ID_IBUS = 1'b0;
  localparam logic BUS_ID_DBUS = 1'b1;
  localparam int   BUS_STRB_W  = 4;

  typedef enum logic [1:0] {
    ARB_FREE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_id_fifo.sv
// bus_id_fifo
//   In-order FIFO of 1-bit requester tags, one entry per accepted but not yet
//   answered memory transaction. Depth may be any value 1..8; pointers wrap
//   modulo DEPTH rather than relying on power-of-2 overflow.
// Ports:
//   clk, rst_b     clock, asynchronous active-low reset
//   push, push_id  enqueue a tag (caller guarantees not full unless popping)
//   pop            dequeue the head (caller guarantees not empty)
//   head_id        tag at the head
//   cnt            current occupancy
//   full, empty    occupancy flags
module bus_id_fifo #(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head_id,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0] ids;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_id = ids[rd_ptr];
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one split-transaction memory port between the fetch bus (ibus,
//   read-only) and the data bus (dbus). dbus wins when both request, except
//   that a request already presented but not yet accepted keeps the grant
//   until accepted. Responses return in order; an ID FIFO routes each one to
//   the requester that issued it. Request and response paths are purely
//   combinational; only the grant lock, the ID FIFO and resp_err hold state.
// Ports:
//   clk, rst_b                     clock, asynchronous active-low reset
//   ibus_*                         fetch request/response
//   dbus_*                         load/store request/response
//   mbus_*                         shared memory port
//   resp_err                       sticky: response seen with nothing outstanding
//
// state      | meaning
// ARB_FREE   | no pending unaccepted request; dbus has priority
// ARB_LOCK_I | ibus request presented, waiting for mbus_addr_ok
// ARB_LOCK_D | dbus request presented, waiting for mbus_addr_ok
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  ibus_req,
  input  logic [XLEN-1:0]       ibus_addr,
  output logic                  ibus_addr_ok,
  output logic                  ibus_data_ok,
  output logic [XLEN-1:0]       ibus_rdata,
  input  logic                  dbus_req,
  input  logic                  dbus_write,
  input  logic [BUS_STRB_W-1:0] dbus_wstrb,
  input  logic [XLEN-1:0]       dbus_addr,
  input  logic [XLEN-1:0]       dbus_wdata,
  output logic                  dbus_addr_ok,
  output logic                  dbus_data_ok,
  output logic [XLEN-1:0]       dbus_rdata,
  output logic                  mbus_req,
  output logic                  mbus_write,
  output logic [BUS_STRB_W-1:0] mbus_wstrb,
  output logic [XLEN-1:0]       mbus_addr,
  output logic [XLEN-1:0]       mbus_wdata,
  input  logic                  mbus_addr_ok,
  input  logic                  mbus_data_ok,
  input  logic [XLEN-1:0]       mbus_rdata,
  output logic                  resp_err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  arb_state_e       state, state_nxt;
  logic             gnt_id;
  logic             sel_req;
  logic             accept;
  logic             pop;
  logic             head_id;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;

  // A response with an empty FIFO has no owner: it is flagged, not popped.
  assign pop = mbus_data_ok & ~empty;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= ARB_FREE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    gnt_id       = dbus_req ? BUS_ID_DBUS : BUS_ID_IBUS;
    sel_req      = 1'b0;
    mbus_req     = 1'b0;
    accept       = 1'b0;
    ibus_addr_ok = 1'b0;
    dbus_addr_ok = 1'b0;

    case (state)
      ARB_LOCK_I: gnt_id = BUS_ID_IBUS;
      ARB_LOCK_D: gnt_id = BUS_ID_DBUS;
      default:    ;
    endcase

    sel_req = (gnt_id == BUS_ID_DBUS) ? dbus_req : ibus_req;
    // A pop this cycle frees a slot, so a full FIFO does not block issue.
    mbus_req = sel_req & (~full | pop);
    accept   = mbus_req & mbus_addr_ok;

    if (gnt_id == BUS_ID_DBUS) dbus_addr_ok = accept;
    else                       ibus_addr_ok = accept;

    if (accept) begin
      state_nxt = ARB_FREE;
    end else if (mbus_req) begin
      state_nxt = (gnt_id == BUS_ID_DBUS) ? ARB_LOCK_D : ARB_LOCK_I;
    end
  end

  always_comb begin
    if (gnt_id == BUS_ID_DBUS) begin
      mbus_write = dbus_write;
      mbus_wstrb = dbus_wstrb;
      mbus_addr  = dbus_addr;
      mbus_wdata = dbus_wdata;
    end else begin
      mbus_write = 1'b0;
      mbus_wstrb = '0;
      mbus_addr  = ibus_addr;
      mbus_wdata = '0;
    end
  end

  bus_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (accept),
    .push_id (gnt_id),
    .pop     (pop),
    .head_id (head_id),
    .cnt     (cnt),
    .full    (full),
    .empty   (empty)
  );

  assign ibus_data_ok = pop & (head_id == BUS_ID_IBUS);
  assign dbus_data_ok = pop & (head_id == BUS_ID_DBUS);
  assign ibus_rdata   = mbus_rdata;
  assign dbus_rdata   = mbus_rdata;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                          resp_err <= 1'b0;
    else if (mbus_data_ok && cnt == '0)  resp_err <= 1'b1;
  end

endmodule
